// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial adder: computes a + b + cin one bit per clock, LSB first.
// An addition takes WIDTH RUN cycles, then a one-cycle DONE state in which
// done pulses and the registered result is valid. sum/cout (and ovf) hold
// the last completed result until the next completion.
//
// Handshake: start is a request sampled on each rising clk edge; it is
// accepted only in IDLE or DONE (ignored while busy). No ready signal is
// needed: busy=0 means the next start will be accepted. done is a single
// cycle valid strobe for sum/cout/ovf with no back-pressure.
//
// Build option:
//   SERIAL_ADDER_OVF_EN - when defined, adds the ovf output (signed overflow,
//                         carry into MSB XOR carry out of MSB).
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request to begin an addition
//   a, b   in   WIDTH-bit operands, captured on accepted start
//   cin    in   carry-in, captured on accepted start
//   busy   out  high while in RUN
//   done   out  high for the one DONE cycle
//   sum    out  registered WIDTH-bit result
//   cout   out  registered carry out of bit WIDTH-1
//   ovf    out  registered signed overflow (SERIAL_ADDER_OVF_EN only)
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             cout,
  output logic             ovf
`else
  output logic             cout
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_n;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last;

  // One-bit full adder on the current LSBs.
  logic p, g, s, co;
  assign p  = a_sh[0] ^ b_sh[0];
  assign g  = a_sh[0] & b_sh[0];
  assign s  = p ^ carry;
  assign co = g | (p & carry);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state and decoded controls
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    last    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST_BIT) begin
          last    = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        // Back-to-back start goes straight to RUN with no idle gap.
        if (start) begin
          accept  = 1'b1;
          state_n = RUN;
        end else begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Datapath: shift registers, carry, counter and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf    <= 1'b0;
`endif
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b;
      res_sh <= '0;
      carry  <= cin;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= {s, res_sh[WIDTH-1:1]};
      carry  <= co;
      // Hold the counter at its last value so it never wraps.
      if (!last) begin
        cnt <= cnt + CW'(1);
      end
      if (last) begin
        // The final bit is taken directly from the adder so the completed
        // value lands in sum on the same edge as the last shift.
        sum  <= {s, res_sh[WIDTH-1:1]};
        cout <= co;
`ifdef SERIAL_ADDER_OVF_EN
        // carry holds the carry into the MSB during the final bit.
        ovf  <= carry ^ co;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
    .cout  (cout),
    .ovf   (ovf)
`else
    .cout  (cout)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  // Entry layout: {ovf, cout, sum}
  logic [W+1:0] exp_q[$];
  int           total;
  int           passed;
  logic [W-1:0] last_sum;
  logic         last_cout;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference model: plain integer arithmetic on the operands.
  function automatic logic [W+1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic cv);
    longint ua, ub, full, sa, sb, sfull;
    logic   o, c;
    logic [W-1:0] s;
    ua    = longint'(av);
    ub    = longint'(bv);
    full  = ua + ub + longint'(cv);
    s     = W'(full % (longint'(1) << W));
    c     = (full >= (longint'(1) << W));
    sa    = av[W-1] ? ua - (longint'(1) << W) : ua;
    sb    = bv[W-1] ? ub - (longint'(1) << W) : ub;
    sfull = sa + sb + longint'(cv);
    o     = (sfull > (longint'(1) << (W - 1)) - 1) || (sfull < -(longint'(1) << (W - 1)));
    return {o, c, s};
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge: presents a start request for the next rising edge.
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    start = 1'b1;
    a     = av;
    b     = bv;
    cin   = cv;
    exp_q.push_back(model(av, bv, cv));
  endtask

  // Waits for completion of the launched operation and checks it.
  // pulse_at > 0 issues a stray start (operands all ones) in that RUN cycle.
  // Returns positioned at the done negedge.
  task automatic finish_op(input string tag, input int pulse_at);
    int           n;
    int           busy_n;
    bit           hold_ok;
    logic [W+1:0] e;
    busy_n  = 0;
    hold_ok = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    cin   = 1'($urandom);
    for (n = 1; n <= 3 * W && !done; n++) begin
      if (busy) busy_n++;
      if (sum !== last_sum || cout !== last_cout) hold_ok = 1'b0;
      if (n == pulse_at) begin
        start = 1'b1;
        a     = '1;
        b     = '1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    e = exp_q.pop_front();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_latency"}, n, W + 1);
    chk({tag, "_busy_cycles"}, busy_n, W);
    chk({tag, "_held"}, hold_ok, 1);
    chk({tag, "_sum"}, sum, e[W-1:0]);
    chk({tag, "_cout"}, cout, e[W]);
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, "_ovf"}, ovf, e[W+1]);
`endif
    last_sum  = e[W-1:0];
    last_cout = e[W];
  endtask

  // ---------------- stimulus ----------------
  initial begin
    total     = 0;
    passed    = 0;
    last_sum  = '0;
    last_cout = 1'b0;
    start     = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    rst_n     = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    rst_n = 1'b1;

    // First start right after reset release
    launch(8'h0F, 8'h01, 1'b0);
    finish_op("add_0f_01", 0);
    chk("add_0f_01_sum_const", sum, 8'h10);
    // DONE lasts exactly one cycle when start is low
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_not_busy", busy, 0);

    launch(8'hFF, 8'h01, 1'b0);
    finish_op("add_ff_01", 0);
    @(negedge clk);
    launch(8'h7F, 8'h00, 1'b1);
    finish_op("add_7f_00_c", 0);
    @(negedge clk);

    // Stray start in RUN cycle 3 is ignored
    launch(8'h12, 8'h34, 1'b0);
    finish_op("ignore_start", 3);
    chk("ignore_start_sum_const", sum, 8'h46);
    @(negedge clk);

    // Back-to-back: start held through the DONE cycle
    launch(8'h55, 8'h0A, 1'b1);
    finish_op("b2b_first", 0);
    launch(8'h80, 8'h80, 1'b0);
    finish_op("b2b_second", 0);
    chk("b2b_cout_const", cout, 1);
    @(negedge clk);

    // Reset in RUN cycle 4 aborts with nothing visible
    launch(8'hAA, 8'h55, 1'b1);
    repeat (4) @(negedge clk);
    start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    void'(exp_q.pop_back());
    last_sum  = '0;
    last_cout = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    launch(8'h01, 8'h01, 1'b0);
    finish_op("after_abort", 0);
    chk("after_abort_sum_const", sum, 8'h02);

    // Randomized operations, random idle gap or back-to-back
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 0) @(negedge clk);
      launch(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
      finish_op($sformatf("rand%0d", i), ($urandom_range(0, 3) == 0) ? $urandom_range(1, W - 1) : 0);
    end

    @(negedge clk);
    chk("final_idle", busy, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
